// File: rtl/dest_sel_pipe.sv
// Destination-register select pipeline: picks the write-back address (link or decoded),
// carries it through DEPTH elastic stages and reports RAW hazards against in-flight writes.
module dest_sel_pipe #(
  parameter int                ADDR_W        = 5,
  parameter logic [ADDR_W-1:0] LINK_ADDR     = {ADDR_W{1'b1}},
  parameter int                DEPTH         = 2,
  parameter bit                ZERO_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              link,
  input  logic              in_wr_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_wr_en,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              hazard,
  output logic [2:0]        occupancy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and in_ready is low during reset and flush cycles.

  logic [DEPTH-1:0]  stg_v;
  logic [ADDR_W-1:0] stg_a [DEPTH];
  logic [DEPTH-1:0]  stg_w;

  logic [DEPTH-1:0]  load;
  logic [DEPTH-1:0]  src_v;
  logic [ADDR_W-1:0] src_a [DEPTH];
  logic [DEPTH-1:0]  src_w;
  logic              can_move;
  logic              accept;
  logic [ADDR_W-1:0] dest;
  logic              dest_wr;

  assign dest    = link ? LINK_ADDR : in_addr;
  assign dest_wr = (ZERO_SUPPRESS && (dest == '0)) ? 1'b0 : in_wr_en;

  // A stage can take new data if it is empty or everything between it and the
  // output either has a hole or drains through out_ready.
  always_comb begin
    load     = '0;
    can_move = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      load[i]  = !stg_v[i] || can_move;
      can_move = load[i];
    end
  end

  assign in_ready = rst_n && !flush && load[0];
  assign accept   = in_valid && in_ready;

  always_comb begin
    src_v    = '0;
    src_w    = '0;
    for (int i = 0; i < DEPTH; i++) src_a[i] = '0;
    src_v[0] = accept;
    src_a[0] = dest;
    src_w[0] = dest_wr;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = stg_v[i-1];
      src_a[i] = stg_a[i-1];
      src_w[i] = stg_w[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_v <= '0;
      stg_w <= '0;
      for (int i = 0; i < DEPTH; i++) stg_a[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush)        stg_v[i] <= 1'b0;
        else if (load[i]) stg_v[i] <= src_v[i];
        // Payload only moves with a valid entry so a stalled output stays stable.
        if (load[i] && src_v[i]) begin
          stg_a[i] <= src_a[i];
          stg_w[i] <= src_w[i];
        end
      end
    end
  end

  always_comb begin
    hazard    = 1'b0;
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + 3'(stg_v[i]);
      if (stg_v[i] && stg_w[i] && (stg_a[i] == query_addr)) hazard = 1'b1;
    end
  end

  assign out_valid = stg_v[DEPTH-1];
  assign out_addr  = stg_a[DEPTH-1];
  assign out_wr_en = stg_v[DEPTH-1] && stg_w[DEPTH-1];

endmodule

// File: tb/tb_dest_sel_pipe.sv
// Directed bench for dest_sel_pipe (DEPTH=2, ADDR_W=5) with hand-computed expectations.
module tb_dest_sel_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_addr;
  logic       link;
  logic       in_wr_en;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_addr;
  logic       out_wr_en;
  logic [4:0] query_addr;
  logic       hazard;
  logic [2:0] occupancy;

  int checks = 0;
  int errors = 0;

  dest_sel_pipe #(.ADDR_W(5), .DEPTH(2), .ZERO_SUPPRESS(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .link       (link),
    .in_wr_en   (in_wr_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_wr_en  (out_wr_en),
    .query_addr (query_addr),
    .hazard     (hazard),
    .occupancy  (occupancy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic l, input logic w);
    in_valid = v;
    in_addr  = a;
    link     = l;
    in_wr_en = w;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; query_addr = 5'd0;
    drive(1'b1, 5'd3, 1'b0, 1'b1);
    #3;
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_out_addr",  8'(out_addr),  8'd0);
    chk("rst_out_wr_en", 8'(out_wr_en), 8'd0);
    chk("rst_hazard",    8'(hazard),    8'd0);
    chk("rst_occupancy", 8'(occupancy), 8'd0);
    chk("rst_in_ready",  8'(in_ready),  8'd0);
    tick();
    chk("rst_no_accept", 8'(occupancy), 8'd0);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 1'b0);

    // Link selection: one entry, latency DEPTH
    tick();
    drive(1'b1, 5'd7, 1'b1, 1'b1);
    #1;
    chk("link_in_ready", 8'(in_ready), 8'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("link_occ1",     8'(occupancy), 8'd1);
    chk("link_not_out",  8'(out_valid), 8'd0);
    tick();
    chk("link_out_valid", 8'(out_valid), 8'd1);
    chk("link_out_addr",  8'(out_addr),  8'd31);
    chk("link_out_wr_en", 8'(out_wr_en), 8'd1);
    tick();
    chk("link_drained", 8'(out_valid), 8'd0);

    // Back-to-back 3,4,5 at full throughput
    drive(1'b1, 5'd3, 1'b0, 1'b1);
    #1;
    chk("b2b_ready_3", 8'(in_ready), 8'd1);
    tick();
    drive(1'b1, 5'd4, 1'b0, 1'b1);
    #1;
    chk("b2b_ready_4", 8'(in_ready), 8'd1);
    tick();
    chk("b2b_out_3", 8'(out_addr), 8'd3);
    chk("b2b_val_3", 8'(out_valid), 8'd1);
    drive(1'b1, 5'd5, 1'b0, 1'b1);
    #1;
    chk("b2b_ready_5", 8'(in_ready), 8'd1);
    tick();
    chk("b2b_out_4", 8'(out_addr), 8'd4);
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("b2b_out_5", 8'(out_addr), 8'd5);
    chk("b2b_val_5", 8'(out_valid), 8'd1);
    tick();
    chk("b2b_empty", 8'(occupancy), 8'd0);

    // Backpressure: 8,9 fill the pipe, 10 must wait
    out_ready = 1'b0;
    drive(1'b1, 5'd8, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd9, 1'b0, 1'b1);
    #1;
    chk("bp_ready_9", 8'(in_ready), 8'd1);
    tick();
    drive(1'b1, 5'd10, 1'b0, 1'b1);
    #1;
    chk("bp_occ2",     8'(occupancy), 8'd2);
    chk("bp_not_rdy",  8'(in_ready),  8'd0);
    chk("bp_hold_8a",  8'(out_addr),  8'd8);
    tick();
    chk("bp_hold_8b",  8'(out_addr),  8'd8);
    chk("bp_occ2b",    8'(occupancy), 8'd2);
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_rel_8", 8'(out_addr), 8'd8);
    tick();
    chk("bp_rel_9",  8'(out_addr),  8'd9);
    chk("bp_occ1",   8'(occupancy), 8'd1);
    tick();
    chk("bp_empty",  8'(occupancy), 8'd0);

    // Zero suppression and write-disabled entries never raise hazard
    drive(1'b1, 5'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd6, 1'b0, 1'b0);
    query_addr = 5'd0;
    #1;
    chk("zs_hazard0", 8'(hazard), 8'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    chk("zs_out_addr",  8'(out_addr),  8'd0);
    chk("zs_out_wr_en", 8'(out_wr_en), 8'd0);
    query_addr = 5'd6;
    #1;
    chk("nowr_hazard", 8'(hazard), 8'd0);
    tick();
    tick();

    // Hazard on in-flight write, then flush clears it
    out_ready = 1'b0;
    drive(1'b1, 5'd12, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    query_addr = 5'd12;
    #1;
    chk("hz_hit", 8'(hazard), 8'd1);
    query_addr = 5'd13;
    #1;
    chk("hz_miss", 8'(hazard), 8'd0);
    query_addr = 5'd12;
    flush = 1'b1;
    drive(1'b1, 5'd13, 1'b0, 1'b1);
    #1;
    chk("fl_no_ready", 8'(in_ready), 8'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("fl_occ0",   8'(occupancy), 8'd0);
    chk("fl_hazard", 8'(hazard),    8'd0);
    chk("fl_outv",   8'(out_valid), 8'd0);

    // Asynchronous reset with a full pipe, then resume
    drive(1'b1, 5'd1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd2, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("ar_occ2", 8'(occupancy), 8'd2);
    rst_n = 1'b0;
    #1;
    chk("ar_outv",  8'(out_valid), 8'd0);
    chk("ar_occ0",  8'(occupancy), 8'd0);
    chk("ar_addr",  8'(out_addr),  8'd0);
    chk("ar_ready", 8'(in_ready),  8'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 5'd17, 1'b0, 1'b1);
    #1;
    chk("ar_resume_ready", 8'(in_ready), 8'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    chk("ar_resume_occ", 8'(occupancy), 8'd1);
    tick();
    chk("ar_resume_addr", 8'(out_addr),  8'd17);
    chk("ar_resume_wr",   8'(out_wr_en), 8'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_sel_pipe.md
DEST_SEL_PIPE -- requirements
Module: dest_sel_pipe

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the register-address width.
REQ-002 Parameter LINK_ADDR, default all-ones ({ADDR_W{1'b1}}), SHALL be the address forced when link is asserted.
REQ-003 Parameter DEPTH, default 2, legal range 1..4, SHALL set the number of pipeline stages.
REQ-004 Parameter ZERO_SUPPRESS, default 1, SHALL enable write suppression for address 0.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream holds a valid destination request.
REQ-008 in_ready  output  1  block accepts a request this cycle.
REQ-009 in_addr  input  ADDR_W  decoded destination register.
REQ-010 link  input  1  selects LINK_ADDR instead of in_addr (jump-and-link).
REQ-011 in_wr_en  input  1  request writes the register file.
REQ-012 flush  input  1  discards all in-flight entries.
REQ-013 out_valid  output  1  last stage holds a valid entry.
REQ-014 out_ready  input  1  downstream consumes the entry this cycle.
REQ-015 out_addr  output  ADDR_W  destination address of the last stage.
REQ-016 out_wr_en  output  1  write enable of the last stage.
REQ-017 query_addr  input  ADDR_W  source address to check for hazards.
REQ-018 hazard  output  1  an in-flight entry will write query_addr.
REQ-019 occupancy  output  3  count of valid stages.

Function
REQ-020 Selection SHALL be dest = link ? LINK_ADDR : in_addr, computed combinationally before stage 0.
REQ-021 When ZERO_SUPPRESS=1 and dest==0, the stored write enable SHALL be 0; otherwise it SHALL equal in_wr_en.
REQ-022 A request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-023 Each stage i SHALL hold {valid, addr, wr_en}; stage i SHALL load from stage i-1 (stage 0 from the input) when stage i is empty or stage i itself advances.
REQ-024 The last stage advances when out_valid && out_ready.
REQ-025 in_ready SHALL be !flush && (stage 0 empty || stage 0 advances) -- full throughput with no bubble under continuous out_ready=1.
REQ-026 With no stalls, an entry accepted at edge k SHALL present out_valid=1 after edge k+DEPTH-1 and be consumed at edge k+DEPTH.
REQ-027 Under out_ready=0, entries SHALL compact forward into empty stages and SHALL NOT be dropped, duplicated, or reordered; out_addr/out_wr_en SHALL stay stable while out_valid && !out_ready.
REQ-028 Flush SHALL clear every valid bit on the next edge; no request SHALL be accepted during a flush cycle; an output handshake in the same cycle still counts as consumed.
REQ-029 hazard SHALL be combinational: OR over valid stages of (wr_en && addr==query_addr).
REQ-030 With ZERO_SUPPRESS=1, query_addr==0 SHALL never raise hazard.
REQ-031 occupancy SHALL equal the number of set valid bits, range 0..DEPTH.
REQ-032 out_addr and out_wr_en SHALL be driven from the last stage registers; when out_valid=0, out_wr_en SHALL be 0.

Reset
REQ-033 rst_n low SHALL immediately clear all valid bits, addr and wr_en registers to 0, independent of clk.
REQ-034 During reset: out_valid=0, out_addr=0, out_wr_en=0, hazard=0, occupancy=0, in_ready=0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight entries; the first edge after deassertion SHALL accept a request if in_valid=1.

Verification (DEPTH=2, ADDR_W=5)
REQ-036 link=1, in_addr=5'd7, in_wr_en=1, out_ready=1, accept at edge 0 -> out_valid=1, out_addr=31, out_wr_en=1 after edge 1.
REQ-037 Back-to-back addrs 3,4,5 with link=0, out_ready=1 -> out_addr sequence 3,4,5 on consecutive cycles, in_ready constant 1.
REQ-038 out_ready=0, push addrs 8,9 -> occupancy=2, in_ready=0, out_addr held at 8; release out_ready -> 8 then 9, no loss.
REQ-039 in_addr=0, link=0, in_wr_en=1 -> out_wr_en=0; query_addr=0 -> hazard=0.
REQ-040 Entry addr 12 in stage 0, query_addr=12 -> hazard=1; assert flush one cycle -> next cycle occupancy=0, hazard=0.
REQ-041 rst_n low asynchronously with occupancy=2 -> out_valid=0 before the next clock edge; release -> normal acceptance resumes.
